// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller and the single-cycle control unit:
// MIPS funct codes, ALU op encodings and the issue FSM state type.
package alu_ctrl_pkg;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SLL = 3'b011;
    localparam logic [2:0] ALUOP_SRL = 3'b100;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signals of the issue controller.
// slave is the controller's view; master is the decode stage / ALU / consumer side.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [4:0]       req_shamt;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c32;
    logic             alu_z;
    logic             alu_v;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_ovf;
    logic             rsp_carry;
    logic             rsp_illegal;

    modport slave (
        input  req_valid, req_funct, req_shamt, req_a, req_b,
        input  alu_result, alu_c32, alu_z, alu_v,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_shamt,
        output rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_carry, rsp_illegal
    );

    modport master (
        output req_valid, req_funct, req_shamt, req_a, req_b,
        output alu_result, alu_c32, alu_z, alu_v,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_shamt,
        input  rsp_valid, rsp_result, rsp_zero, rsp_ovf, rsp_carry, rsp_illegal
    );

endinterface

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder: ALU op code, whether the adder flags are meaningful,
// and whether the funct is supported at all. Shared with the single-cycle control unit.
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       is_arith,
    output logic       illegal
);

    always_comb begin
        alu_op   = ALUOP_AND;
        is_arith = 1'b0;
        illegal  = 1'b0;
        case (funct)
            FUNCT_AND: alu_op = ALUOP_AND;
            FUNCT_OR:  alu_op = ALUOP_OR;
            FUNCT_ADD: begin
                alu_op   = ALUOP_ADD;
                is_arith = 1'b1;
            end
            FUNCT_SUB: begin
                alu_op   = ALUOP_SUB;
                is_arith = 1'b1;
            end
            FUNCT_SLT: alu_op = ALUOP_SLT;
            FUNCT_SLL: alu_op = ALUOP_SLL;
            FUNCT_SRL: alu_op = ALUOP_SRL;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator for the combinational ALU: registers operands/op, waits SETTLE_CYCLES,
// captures result and flags, and returns them over a valid/ready response channel.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int WIDTH         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYCLES must be within 1..15");
    end
    if (WIDTH != 32) begin : g_bad_width
        $error("alu_issue_ctrl: WIDTH must be 32 to match the ALU");
    end

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0] dec_op;
    logic       dec_is_arith;
    logic       dec_illegal;

    alu_funct_decode u_decode (
        .funct    (bus.req_funct),
        .alu_op   (dec_op),
        .is_arith (dec_is_arith),
        .illegal  (dec_illegal)
    );

    issue_state_e     state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [4:0]       alu_shamt_q, alu_shamt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    // The ALU's own zero flag only follows the adder, so it is deliberately ignored.
    logic unused_alu_z;
    assign unused_alu_z = bus.alu_z;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        arith_d       = arith_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        alu_shamt_d   = alu_shamt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (dec_illegal) begin
                        // Rejected requests skip the ALU entirely and leave its inputs untouched.
                        rsp_result_d  = '0;
                        rsp_zero_d    = 1'b0;
                        rsp_ovf_d     = 1'b0;
                        rsp_carry_d   = 1'b0;
                        rsp_illegal_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        state_d       = ST_RESP;
                    end else begin
                        alu_a_d     = bus.req_a;
                        alu_b_d     = bus.req_b;
                        alu_op_d    = dec_op;
                        alu_shamt_d = bus.req_shamt;
                        arith_d     = dec_is_arith;
                        cnt_d       = SETTLE_LOAD;
                        state_d     = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d  = bus.alu_result;
                    rsp_zero_d    = ~|bus.alu_result;
                    rsp_ovf_d     = arith_q & bus.alu_v;
                    rsp_carry_d   = arith_q & bus.alu_c32;
                    rsp_illegal_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            arith_q       <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= ALUOP_AND;
            alu_shamt_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_carry_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            arith_q       <= arith_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            alu_shamt_q   <= alu_shamt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign bus.req_ready   = rst_n && (state_q == ST_IDLE);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_shamt   = alu_shamt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_ovf     = rsp_ovf_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized requests
// compared against an arithmetic reference model; a behavioural ALU answers the DUT.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int testCount = 0;
    int failCount = 0;
    logic [2:0]  lastOp;
    logic [31:0] lastA;
    logic [31:0] lastB;
    logic [4:0]  lastShamt;

    // Behavioural ALU; its carry/overflow always come from the adder and its zero flag
    // ignores shifts, so the controller's own flag handling is what gets observed.
    logic [32:0] stubSum;
    longint      stubSSum;
    logic [31:0] stubRes;
    always_comb begin
        stubSum  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        stubSSum = longint'($signed(bus.alu_a)) + longint'($signed(bus.alu_b));
        if (bus.alu_op == 3'b110) begin
            stubSum  = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
            stubSSum = longint'($signed(bus.alu_a)) - longint'($signed(bus.alu_b));
        end
        case (bus.alu_op)
            3'b000:  stubRes = bus.alu_a & bus.alu_b;
            3'b001:  stubRes = bus.alu_a | bus.alu_b;
            3'b011:  stubRes = bus.alu_a << bus.alu_shamt;
            3'b100:  stubRes = bus.alu_a >> bus.alu_shamt;
            3'b111:  stubRes = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: stubRes = stubSum[31:0];
        endcase
        bus.alu_result = stubRes;
        bus.alu_c32    = stubSum[32];
        bus.alu_v      = (stubSSum > 64'sd2147483647) || (stubSSum < -64'sd2147483648);
        bus.alu_z      = (bus.alu_op == 3'b011 || bus.alu_op == 3'b100) ? 1'b0 : (stubSum[31:0] == 32'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic void refModel(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] shamt, output logic legal, output logic [2:0] op,
                                     output logic [31:0] res, output logic zero, output logic ovf,
                                     output logic carry);
        legal = 1'b1;
        op    = 3'b000;
        res   = 32'd0;
        ovf   = 1'b0;
        carry = 1'b0;
        case (funct)
            6'h20: begin
                op    = 3'b010;
                res   = a + b;
                carry = (res < a);
                ovf   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            6'h22: begin
                op    = 3'b110;
                res   = a - b;
                carry = (a >= b);
                ovf   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            6'h24: begin op = 3'b000; res = a & b; end
            6'h25: begin op = 3'b001; res = a | b; end
            6'h2A: begin op = 3'b111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            6'h00: begin op = 3'b011; res = a << shamt; end
            6'h02: begin op = 3'b100; res = a >> shamt; end
            default: legal = 1'b0;
        endcase
        zero = legal && (res == 32'd0);
    endfunction

    // One full transaction; keepValid leaves an unrelated request pending while busy.
    task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] shamt, input int holdCycles, input bit keepValid);
        logic        legal;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        carry;
        int          lat;
        refModel(funct, a, b, shamt, legal, op, res, zero, ovf, carry);
        if (legal) begin
            lastOp    = op;
            lastA     = a;
            lastB     = b;
            lastShamt = shamt;
        end
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_funct = funct;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_shamt = shamt;
        @(negedge clk);
        if (keepValid) begin
            bus.req_funct = FUNCT_ADD;
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            bus.req_shamt = 5'($urandom);
        end else begin
            bus.req_valid = 1'b0;
        end
        checkOutput("alu_op_after_accept", 32'(bus.alu_op), 32'(lastOp));
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), legal ? 32'(SETTLE) : 32'd0);
        checkOutput("rsp_result", bus.rsp_result, res);
        checkOutput("rsp_zero", 32'(bus.rsp_zero), 32'(zero));
        checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(ovf));
        checkOutput("rsp_carry", 32'(bus.rsp_carry), 32'(carry));
        checkOutput("rsp_illegal", 32'(bus.rsp_illegal), 32'(!legal));
        checkOutput("alu_a_held", bus.alu_a, lastA);
        checkOutput("alu_b_held", bus.alu_b, lastB);
        checkOutput("alu_shamt_held", 32'(bus.alu_shamt), 32'(lastShamt));
        repeat (holdCycles) begin
            @(negedge clk);
            checkOutput("rsp_valid_stall", 32'(bus.rsp_valid), 32'd1);
            checkOutput("rsp_result_stall", bus.rsp_result, res);
            checkOutput("req_ready_stall", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        checkOutput("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
        checkOutput("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
        checkOutput("alu_op_no_bypass", 32'(bus.alu_op), 32'(lastOp));
        checkOutput("alu_a_no_bypass", bus.alu_a, lastA);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_funct = 6'h00;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_shamt = 5'd0;
        bus.rsp_ready = 1'b0;
        lastOp        = 3'b000;
        lastA         = 32'd0;
        lastB         = 32'd0;
        lastShamt     = 5'd0;
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("reset_alu_a", bus.alu_a, 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_result", bus.rsp_result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(FUNCT_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0, 1'b0);
        applyStimulus(FUNCT_SUB, 32'd5, 32'd5, 5'd0, 1, 1'b0);
        applyStimulus(FUNCT_SLL, 32'h00000003, 32'h0, 5'd31, 0, 1'b0);
        applyStimulus(FUNCT_SRL, 32'h00000001, 32'h0, 5'd1, 0, 1'b0);
        applyStimulus(6'h18, 32'h12345678, 32'h9ABCDEF0, 5'd3, 0, 1'b0);
        applyStimulus(FUNCT_OR, 32'hF0F00000, 32'h0000A5A5, 5'd0, 5, 1'b1);
        applyStimulus(FUNCT_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0, 0, 1'b0);
        applyStimulus(FUNCT_SUB, 32'h80000000, 32'h00000001, 5'd0, 0, 1'b0);

        // Reset in the middle of a settle window must abort with no response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_funct = FUNCT_ADD;
        bus.req_a     = 32'h11;
        bus.req_b     = 32'h22;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("abort_alu_a_loaded", bus.alu_a, 32'h11);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_alu_a", bus.alu_a, 32'd0);
        checkOutput("abort_alu_b", bus.alu_b, 32'd0);
        checkOutput("abort_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd0);
        lastOp    = 3'b000;
        lastA     = 32'd0;
        lastB     = 32'd0;
        lastShamt = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        applyStimulus(FUNCT_ADD, 32'h00000010, 32'h00000020, 5'd0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [5:0]  f;
            logic [31:0] ra;
            logic [31:0] rb;
            case ($urandom_range(0, 7))
                0: f = FUNCT_ADD;
                1: f = FUNCT_SUB;
                2: f = FUNCT_AND;
                3: f = FUNCT_OR;
                4: f = FUNCT_SLT;
                5: f = FUNCT_SLL;
                6: f = FUNCT_SRL;
                default: begin
                    f = 6'($urandom);
                    if (f inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_SLL, FUNCT_SRL})
                        f = 6'h3F;
                end
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            applyStimulus(f, ra, rb, 5'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
